// File: rtl/formula_chain_fsm.sv
// formula_chain_fsm: nested isqrt chain over N captured arguments, sharing one external isqrt unit
module formula_chain_fsm #(
  parameter int N = 3,
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [N*W-1:0]   args,
  output logic             res_vld,
  output logic [W-1:0]     res,
  output logic             isqrt_x_vld,
  output logic [W-1:0]     isqrt_x,
  input  logic             isqrt_y_vld,
  input  logic [W/2-1:0]   isqrt_y
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;
  logic [W-1:0] arg_q [N];
  logic [W-1:0] arg_d [N];
  logic [IW-1:0] idx_q, idx_d;
  logic [W/2-1:0] acc_q, acc_d, res_q, res_d;
  logic res_vld_q, res_vld_d;
  logic [W-1:0] sel;
  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) sel = (idx_q == IW'(k)) ? arg_q[k] : sel;
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    res_d = res_q;
    res_vld_d = 1'b0;
    for (int k = 0; k < N; k++) arg_d[k] = arg_q[k];
    case (state_q)
      IDLE: if (arg_vld) begin
        for (int k = 0; k < N; k++) arg_d[k] = args[k*W +: W];
        idx_d = IW'(N - 1);
        acc_d = '0;
        state_d = ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (isqrt_y_vld) begin
        if (idx_q != '0) begin
          acc_d = isqrt_y;
          idx_d = idx_q - 1'b1;
          state_d = ISSUE;
        end else begin
          res_d = isqrt_y;
          res_vld_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      acc_q <= '0;
      res_q <= '0;
      res_vld_q <= 1'b0;
      for (int k = 0; k < N; k++) arg_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      res_q <= res_d;
      res_vld_q <= res_vld_d;
      for (int k = 0; k < N; k++) arg_q[k] <= arg_d[k];
    end
  end
  assign arg_rdy = state_q == IDLE;
  assign isqrt_x_vld = state_q == ISSUE;
  assign isqrt_x = sel + {{(W/2){1'b0}}, acc_q};
  assign res_vld = res_vld_q;
  assign res = {{(W/2){1'b0}}, res_q};
endmodule

// File: tb/tb_formula_chain_fsm.sv
// tb_formula_chain_fsm: directed checks of three chain depths against a latency-2 isqrt model
module tb_formula_chain_fsm;
  logic clk = 0;
  logic rst;
  logic av [3];
  logic rd [3];
  logic rv [3];
  logic [31:0] rs [3];
  logic xv [3];
  logic [31:0] xd [3];
  logic yv [3];
  logic [15:0] yd [3];
  logic [95:0] a3;
  logic [63:0] a2;
  logic [31:0] a1;
  logic pv1 [3], pv2 [3];
  logic [15:0] pd1 [3], pd2 [3];
  logic inj_idle, spur_en, inj;
  logic [31:0] xq0 [$], xq1 [$], xq2 [$];
  int tests = 0, fails = 0, c;
  logic rdy_bad;

  always #5 clk = ~clk;

  formula_chain_fsm #(.N(3), .W(32)) d3 (.clk(clk), .rst(rst), .arg_vld(av[0]), .arg_rdy(rd[0]),
    .args(a3), .res_vld(rv[0]), .res(rs[0]), .isqrt_x_vld(xv[0]), .isqrt_x(xd[0]),
    .isqrt_y_vld(yv[0]), .isqrt_y(yd[0]));
  formula_chain_fsm #(.N(1), .W(32)) d1 (.clk(clk), .rst(rst), .arg_vld(av[1]), .arg_rdy(rd[1]),
    .args(a1), .res_vld(rv[1]), .res(rs[1]), .isqrt_x_vld(xv[1]), .isqrt_x(xd[1]),
    .isqrt_y_vld(yv[1]), .isqrt_y(yd[1]));
  formula_chain_fsm #(.N(2), .W(32)) d2 (.clk(clk), .rst(rst), .arg_vld(av[2]), .arg_rdy(rd[2]),
    .args(a2), .res_vld(rv[2]), .res(rs[2]), .isqrt_x_vld(xv[2]), .isqrt_x(xd[2]),
    .isqrt_y_vld(yv[2]), .isqrt_y(yd[2]));

  function automatic logic [15:0] isq(input logic [31:0] x);
    logic [15:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pv1[i] <= 1'b0;
        pv2[i] <= 1'b0;
      end else begin
        pv1[i] <= xv[i];
        pv2[i] <= pv1[i];
        pd1[i] <= isq(xd[i]);
        pd2[i] <= pd1[i];
      end
    end

  assign inj = inj_idle | (spur_en & xv[0]);
  assign yv[0] = pv2[0] | inj;
  assign yd[0] = inj ? 16'd170 : pd2[0];
  assign yv[1] = pv2[1];
  assign yd[1] = pd2[1];
  assign yv[2] = pv2[2];
  assign yd[2] = pd2[2];

  always @(negedge clk) begin
    if (xv[0] === 1'b1) xq0.push_back(xd[0]);
    if (xv[1] === 1'b1) xq1.push_back(xd[1]);
    if (xv[2] === 1'b1) xq2.push_back(xd[2]);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_res(input int i, output int cyc);
    cyc = 1;
    while (rv[i] !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  initial begin
    rst = 1; inj_idle = 0; spur_en = 0;
    for (int i = 0; i < 3; i++) av[i] = 0;
    a3 = '0; a2 = '0; a1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_arg_rdy", rd[0], 1);
    chk("rst_res_vld", rv[0], 0);
    chk("rst_res", rs[0], 0);
    chk("rst_x_vld", xv[0], 0);

    xq0.delete();
    a3 = {32'd16, 32'd21, 32'd11}; av[0] = 1;
    @(posedge clk); #1 av[0] = 0;
    wait_res(0, c);
    chk("t1_latency", c, 10);
    chk("t1_res", rs[0], 4);
    chk("t1_nx", xq0.size(), 3);
    chk("t1_x0", xq0[0], 16);
    chk("t1_x1", xq0[1], 25);
    chk("t1_x2", xq0[2], 16);
    chk("t1_rdy_at_res", rd[0], 1);
    @(posedge clk); #1;
    chk("t1_pulse_width", rv[0], 0);
    chk("t1_res_hold", rs[0], 4);

    xq1.delete();
    a1 = 32'd1000000; av[1] = 1;
    @(posedge clk); #1 av[1] = 0;
    wait_res(1, c);
    chk("n1_latency", c, 4);
    chk("n1_res", rs[1], 1000);
    chk("n1_nx", xq1.size(), 1);
    chk("n1_x0", xq1[0], 1000000);

    xq2.delete();
    a2 = {32'hFFFF_FFFF, 32'hFFFF_FFFF}; av[2] = 1;
    @(posedge clk); #1 av[2] = 0;
    wait_res(2, c);
    chk("wrap_latency", c, 7);
    chk("wrap_res", rs[2], 255);
    chk("wrap_x0", xq2[0], 32'hFFFF_FFFF);
    chk("wrap_x1", xq2[1], 65534);

    @(posedge clk); #1;
    a3 = {32'd16, 32'd21, 32'd11}; av[0] = 1;
    @(posedge clk); #1;
    a3 = {32'd0, 32'd0, 32'd9};
    rdy_bad = 0; c = 1;
    while (rv[0] !== 1'b1 && c < 100) begin
      if (rd[0] !== 1'b0) rdy_bad = 1;
      @(posedge clk); #1;
      c++;
    end
    chk("bp_rdy_low_busy", rdy_bad, 0);
    chk("bp_latency1", c, 10);
    chk("bp_res1", rs[0], 4);
    chk("bp_rdy_at_res", rd[0], 1);
    @(posedge clk); #1 av[0] = 0;
    chk("bp_accepted", rd[0], 0);
    wait_res(0, c);
    chk("bp_latency2", c, 10);
    chk("bp_res2", rs[0], 3);

    @(posedge clk); #1;
    a3 = {32'd16, 32'd21, 32'd11}; av[0] = 1;
    @(posedge clk); #1 av[0] = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rmid_rdy", rd[0], 1);
    chk("rmid_res", rs[0], 0);
    inj_idle = 1;
    @(posedge clk); #1 inj_idle = 0;
    c = 0;
    for (int i = 0; i < 15; i++) begin
      if (rv[0] !== 1'b0) c++;
      @(posedge clk); #1;
    end
    chk("rmid_no_res_vld", c, 0);
    chk("rmid_res_after", rs[0], 0);
    chk("rmid_rdy_after", rd[0], 1);
    a3 = {32'd16, 32'd21, 32'd11}; av[0] = 1;
    @(posedge clk); #1 av[0] = 0;
    wait_res(0, c);
    chk("rmid_next_res", rs[0], 4);

    @(posedge clk); #1;
    inj_idle = 1;
    @(posedge clk); #1 inj_idle = 0;
    chk("spur_idle_rdy", rd[0], 1);
    chk("spur_idle_res", rs[0], 4);
    chk("spur_idle_no_vld", rv[0], 0);
    spur_en = 1;
    a3 = {32'd0, 32'd0, 32'd9}; av[0] = 1;
    @(posedge clk); #1 av[0] = 0;
    wait_res(0, c);
    spur_en = 0;
    chk("spur_latency", c, 10);
    chk("spur_res", rs[0], 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/formula_chain_fsm.md
# formula_chain_fsm

Parametrised successor of the fixed three-term nested-root FSM. Computes res = isqrt(a[0] + isqrt(a[1] + … + isqrt(a[N-1]))) for N arguments of W bits. It time-shares one external isqrt instance through the same x/y handshake, and adds argument capture and an input-ready handshake. It sits between an argument producer and the shared isqrt unit.

## Interface
- N, default 3: number of chained terms; legal range N ≥ 1.
- W, default 32: argument, isqrt input and result width; even, ≥ 4.
- clk  input  1: clock; all state updates on the rising edge.
- rst  input  1: reset, synchronous, active-high.
- arg_vld  input  1: argument set valid.
- arg_rdy  output  1: block can accept an argument set.
- args  input  N*W: packed arguments; a[k] = args[k*W +: W]; a[0] is the outermost term.
- res_vld  output  1: one-cycle result strobe.
- res  output  W: result, zero-extended from W/2 bits.
- isqrt_x_vld  output  1: request to the isqrt unit.
- isqrt_x  output  W: isqrt operand.
- isqrt_y_vld  input  1: isqrt result valid.
- isqrt_y  input  W/2: isqrt result.

## Operation
- Acceptance: an argument set is accepted on an edge where arg_vld & arg_rdy. All N arguments are copied into internal registers on that edge; args is not sampled afterwards.
- Registers:
  - idx, ceil(log2 N) bits, minimum 1 bit: stage counter.
  - acc, W/2 bits: previous root.
- States:
  - IDLE: arg_rdy = 1. On acceptance, idx ← N-1, acc ← 0, go to ISSUE.
  - ISSUE: isqrt_x_vld = 1 for exactly one cycle, with isqrt_x = a[idx] + zero-extended acc. The sum is truncated to W bits (modulo 2^W; no saturation). Then go to WAIT.
  - WAIT: hold until isqrt_y_vld.
    - If isqrt_y_vld and idx ≠ 0: acc ← isqrt_y, idx ← idx-1, go to ISSUE.
    - If isqrt_y_vld and idx = 0: res ← isqrt_y, res_vld ← 1 next cycle, go to IDLE.
- arg_rdy = 1 only in IDLE, so one operation is in flight at a time. arg_vld outside IDLE is ignored; the producer holds it.
- isqrt_x_vld = 0 outside ISSUE. isqrt_x is don't-care when isqrt_x_vld = 0.
- isqrt_y_vld outside WAIT is ignored; it does not change state, acc or res.
- res holds its last value until the next final result.

## Timing
- Reset values:
  - state = IDLE, so arg_rdy = 1.
  - res_vld = 0, res = 0, isqrt_x_vld = 0.
  - idx = 0, acc = 0.
- Reset mid-operation: returns to IDLE on the next edge. No res_vld is produced for the aborted set. The isqrt unit shares rst and is flushed with it. A late isqrt_y_vld arriving in IDLE is ignored.
- Latency, with isqrt latency L (x_vld cycle to y_vld cycle, L ≥ 1):
  - Acceptance edge ends cycle T0.
  - First ISSUE is cycle T0+1.
  - Each stage takes L+1 cycles.
  - res_vld is high in cycle T0+1+N·(L+1).
- The res_vld cycle is also an IDLE cycle (arg_rdy = 1). A new set can be accepted on that edge, so back-to-back throughput is one result per 1+N·(L+1) cycles.
- If isqrt_y_vld and the final result coincide with arg_vld, no conflict arises: arg_vld is ignored until IDLE.
- Every output is either a register or decoded from state only; no output depends combinationally on arg_vld or isqrt_y_vld.

## Test plan
- Reset default, N=3, W=32: a[0]=11, a[1]=21, a[2]=16.
  - Required: isqrt_x sequence 16, 25, 16; res=4; res_vld high exactly 1 cycle, in cycle T0+1+3(L+1).
- N=1, W=32: a[0]=1000000 -> single request, isqrt_x=1000000; res=1000; res_vld in cycle T0+2+L.
- Wrap, N=2, W=32: a[1]=0xFFFFFFFF, a[0]=0xFFFFFFFF.
  - Required: first root 65535; second isqrt_x wraps to 65534; res=255.
- Backpressure: hold arg_vld high with a second set (N=3: a[2]=0, a[1]=0, a[0]=9) throughout the first operation.
  - Required: arg_rdy=0 until the res_vld cycle; second set accepted on that edge; second res=3.
  - Required: changing args while busy does not affect the first result.
- Reset mid-operation: assert rst for 1 cycle while in WAIT of stage 1, then inject a stray isqrt_y_vld in IDLE.
  - Required: no res_vld; res=0; arg_rdy=1.
  - Required: a following set (a[2]=16, a[1]=21, a[0]=11) yields res=4.
- Spurious isqrt_y_vld pulses during IDLE and ISSUE -> no state, acc or res change; the result of the concurrent operation is unchanged.
